// File: rtl/tile_render_pkg.sv
// Shared constants, tilemap entry type and the fixed pattern/palette contents for the
// Pac-Man tile renderer.
package tile_render_pkg;

    localparam int unsigned MAP_COLS  = 28;
    localparam int unsigned MAP_ROWS  = 36;
    localparam int unsigned TILE_W    = 8;
    localparam int unsigned PLAY_W    = MAP_COLS * TILE_W;
    localparam int unsigned PLAY_H    = MAP_ROWS * TILE_W;

    localparam int unsigned MAP_AW    = 11;
    localparam int unsigned MAP_DW    = 14;
    localparam int unsigned MAP_DEPTH = 2048;
    localparam int unsigned PAT_DW    = 16;
    localparam int unsigned PAL_AW    = 8;
    localparam int unsigned PAL_DW    = 24;
    localparam int unsigned PAL_DEPTH = 256;

    typedef struct packed {
        logic [5:0] pal;
        logic [7:0] tile;
    } tilemap_entry_t;

    typedef logic [PAL_DEPTH-1:0][PAL_DW-1:0] palette_t;

    function automatic palette_t build_palette();
        palette_t   p;
        logic [7:0] b;
        for (int i = 0; i < int'(PAL_DEPTH); i++) begin
            b    = 8'(i);
            p[i] = (i == 7) ? 24'hFF0000 : {b, ~b, b ^ 8'h5A};
        end
        return p;
    endfunction

    localparam palette_t DEFAULT_PALETTE = build_palette();

    // Pattern ROM row: a value-3 pixel that walks with tile and row, plus a tile*row texture.
    function automatic logic [PAT_DW-1:0] pattern_row(input logic [7:0] tile,
                                                      input logic [2:0] frow);
        logic [2:0] pos;
        pos = tile[2:0] + frow + 3'd3;
        return (16'hC000 >> {pos, 1'b0}) | ({8'd0, tile} * {13'd0, frow});
    endfunction

endpackage

// File: rtl/tile_render_ram.sv
// Single-port RAM with registered read; a write cycle leaves rdata unchanged.
module tile_render_ram #(
    parameter int unsigned Depth = 2048,
    parameter int unsigned Width = 14,
    localparam int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [AddrW-1:0] addr,
    input  logic [Width-1:0] wdata,
    output logic [Width-1:0] rdata
);

    logic [Width-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/pacman_tile_render.sv
// Pac-Man playfield renderer: (x_pos, y_pos) -> rgb through a fixed 4-stage pipeline.
// Define TILE_RENDER_PAL_WR_EN to make the palette writable through the pal_* ports.
module pacman_tile_render
    import tile_render_pkg::*;
#(
    parameter logic [11:0] X0          = 12'd0,
    parameter logic [10:0] Y0          = 11'd0,
    parameter int unsigned SCALE_SHIFT = 1,
    parameter logic [23:0] BG_COLOR    = 24'h000000
) (
    input  logic        PixelClk,
    input  logic        nRST,
    input  logic [11:0] x_pos,
    input  logic [10:0] y_pos,
    output logic [23:0] rgb,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [10:0] wr_addr,
    input  logic [13:0] wr_data
`ifdef TILE_RENDER_PAL_WR_EN
    ,
    input  logic        pal_we,
    input  logic [7:0]  pal_addr,
    input  logic [23:0] pal_data
`endif
);

    logic [12:0] dx;
    logic [11:0] dy;
    logic [11:0] px;
    logic [10:0] py;
    logic        win_d;

    // The extra top bit of dx/dy is the borrow: position left of / above the playfield.
    assign dx    = {1'b0, x_pos} - {1'b0, X0};
    assign dy    = {1'b0, y_pos} - {1'b0, Y0};
    assign px    = dx[11:0] >> SCALE_SHIFT;
    assign py    = dy[10:0] >> SCALE_SHIFT;
    assign win_d = !dx[12] && !dy[11] && (px < 12'(PLAY_W)) && (py < 11'(PLAY_H));

    logic        s0_win_q, s1_win_q, s2_win_q, s3_win_q;
    logic [4:0]  s0_col_q;
    logic [5:0]  s0_row_q;
    logic [2:0]  s0_frow_q, s0_fcol_q, s1_frow_q, s1_fcol_q, s2_fcol_q;
    logic [5:0]  s2_pal_q;
    logic [15:0] s2_pat_q;
    logic [23:0] s3_color_q;
    logic        ready_q;

    tilemap_entry_t      map_rdata;
    logic [MAP_AW-1:0]   map_addr;
    logic                map_we;

    // Display reads own the port whenever the registered window flag is set.
    assign wr_ready = ready_q;
    assign map_we   = wr_valid && ready_q;
    assign map_addr = s0_win_q ? {s0_row_q, s0_col_q} : wr_addr;

    tile_render_ram #(
        .Depth (MAP_DEPTH),
        .Width (MAP_DW)
    ) u_tilemap (
        .clk   (PixelClk),
        .en    (s0_win_q || map_we),
        .we    (map_we),
        .addr  (map_addr),
        .wdata (wr_data),
        .rdata (map_rdata)
    );

    logic [15:0]       pat_shift;
    logic [PAL_AW-1:0] pal_idx;
    logic [PAL_DW-1:0] pal_rdata;

    assign pat_shift = s2_pat_q << {s2_fcol_q, 1'b0};
    assign pal_idx   = {s2_pal_q, pat_shift[15:14]};

`ifdef TILE_RENDER_PAL_WR_EN
    palette_t pal_mem = DEFAULT_PALETTE;

    always_ff @(posedge PixelClk) begin
        if (pal_we) begin
            pal_mem[pal_addr] <= pal_data;
        end
    end

    assign pal_rdata = pal_mem[pal_idx];
`else
    assign pal_rdata = DEFAULT_PALETTE[pal_idx];
`endif

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            s0_win_q   <= 1'b0;
            s0_col_q   <= '0;
            s0_row_q   <= '0;
            s0_frow_q  <= '0;
            s0_fcol_q  <= '0;
            ready_q    <= 1'b1;
            s1_win_q   <= 1'b0;
            s1_frow_q  <= '0;
            s1_fcol_q  <= '0;
            s2_win_q   <= 1'b0;
            s2_fcol_q  <= '0;
            s2_pal_q   <= '0;
            s2_pat_q   <= '0;
            s3_win_q   <= 1'b0;
            s3_color_q <= '0;
            rgb        <= '0;
        end else begin
            s0_win_q   <= win_d;
            s0_col_q   <= px[7:3];
            s0_row_q   <= py[8:3];
            s0_frow_q  <= py[2:0];
            s0_fcol_q  <= px[2:0];
            ready_q    <= !win_d;
            s1_win_q   <= s0_win_q;
            s1_frow_q  <= s0_frow_q;
            s1_fcol_q  <= s0_fcol_q;
            s2_win_q   <= s1_win_q;
            s2_fcol_q  <= s1_fcol_q;
            s2_pal_q   <= map_rdata.pal;
            s2_pat_q   <= pattern_row(map_rdata.tile, s1_frow_q);
            s3_win_q   <= s2_win_q;
            s3_color_q <= pal_rdata;
            rgb        <= s3_win_q ? s3_color_q : BG_COLOR;
        end
    end

endmodule

// File: tb/tb_pacman_tile_render.sv
// Self-checking bench for pacman_tile_render: randomized positions and tilemap writes
// compared against a tile-level playfield model with a 4-sample output delay.
module tb_pacman_tile_render;

    localparam int          X0I   = 0;
    localparam int          Y0I   = 0;
    localparam int          SHIFT = 1;
    localparam logic [23:0] BG    = 24'h000000;

    logic        PixelClk = 1'b0;
    logic        nRST     = 1'b0;
    logic [11:0] x_pos    = 12'd4095;
    logic [10:0] y_pos    = 11'd0;
    logic [23:0] rgb;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [10:0] wr_addr  = '0;
    logic [13:0] wr_data  = '0;
`ifdef TILE_RENDER_PAL_WR_EN
    logic        pal_we   = 1'b0;
    logic [7:0]  pal_addr = '0;
    logic [23:0] pal_data = '0;
`endif

    int checks  = 0;
    int errors  = 0;
    int accepts = 0;

    logic [13:0] model_map [2048];
    logic [23:0] model_pal [256];

    always #5 PixelClk = ~PixelClk;

    pacman_tile_render #(
        .X0          (12'(X0I)),
        .Y0          (11'(Y0I)),
        .SCALE_SHIFT (SHIFT),
        .BG_COLOR    (BG)
    ) u_dut (
        .PixelClk (PixelClk),
        .nRST     (nRST),
        .x_pos    (x_pos),
        .y_pos    (y_pos),
        .rgb      (rgb),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
`ifdef TILE_RENDER_PAL_WR_EN
        ,
        .pal_we   (pal_we),
        .pal_addr (pal_addr),
        .pal_data (pal_data)
`endif
    );

    // Colour the playfield shows at a position, from the tile/pattern/palette rules.
    function automatic logic [23:0] ref_pixel(input int x, input int y);
        int dx, dy, px, py, t, r, pal, word, pix;
        logic [13:0] ent;
        dx = x - X0I;
        dy = y - Y0I;
        if (dx < 0 || dy < 0) return BG;
        px = dx / (1 << SHIFT);
        py = dy / (1 << SHIFT);
        if (px >= 224 || py >= 288) return BG;
        ent  = model_map[(py / 8) * 32 + px / 8];
        t    = int'(ent[7:0]);
        pal  = int'(ent[13:8]);
        r    = py % 8;
        word = (49152 >> (2 * ((t + r + 3) % 8))) | (t * r);
        pix  = (word >> (14 - 2 * (px % 8))) & 3;
        return model_pal[pal * 4 + pix];
    endfunction

    // One clock: present a position, note a write handshake, return the expected colour.
    task automatic cycle(input int x, input int y, output logic [23:0] exp);
        logic acc;
        x_pos = 12'(x);
        y_pos = 11'(y);
        acc   = wr_valid && wr_ready;
        @(posedge PixelClk);
        if (acc) begin
            model_map[wr_addr] = wr_data;
            accepts++;
        end
        exp = ref_pixel(x, y);
        #1;
    endtask

    task automatic test_fill();
        logic [23:0] e;
        int a0;
        for (int r = 0; r < 36; r++) begin
            for (int c = 0; c < 28; c++) begin
                wr_addr  = 11'(r * 32 + c);
                wr_data  = 14'($urandom);
                wr_valid = 1'b1;
                a0       = accepts;
                for (int t = 0; t < 4 && accepts == a0; t++) cycle(4095, 0, e);
                wr_valid = 1'b0;
                checks++;
                if (accepts != a0 + 1) begin
                    $display("FAIL fill_accept addr %0d got %0d transfers want 1", wr_addr,
                             accepts - a0);
                    errors++;
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [23:0] want;
        nRST  = 1'b0;
        x_pos = 12'(X0I);
        y_pos = 11'(Y0I);
        #1;
        checks++;
        if (rgb !== 24'h0) begin
            $display("FAIL reset_rgb got %h want 000000", rgb);
            errors++;
        end
        checks++;
        if (wr_ready !== 1'b1) begin
            $display("FAIL reset_wr_ready got %b want 1", wr_ready);
            errors++;
        end
        @(posedge PixelClk);
        #1;
        nRST = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge PixelClk);
            #1;
            want = (k <= 4) ? 24'h0 : ref_pixel(X0I, Y0I);
            checks++;
            if (rgb !== want) begin
                $display("FAIL release_rgb cycle %0d got %h want %h", k, rgb, want);
                errors++;
            end
        end
    endtask

    task automatic test_directed();
        int          xs [10] = '{48, 4095, 446, 448, 48, 0, 4095, 4095, 4095, 4095};
        int          ys [10] = '{32, 32, 32, 32, 576, 575, 0, 0, 0, 0};
        logic [23:0] q [$];
        logic [23:0] e, w;
        int          a0;
        wr_addr  = 11'(2 * 32 + 3);
        wr_data  = {6'd1, 8'd5};
        wr_valid = 1'b1;
        a0       = accepts;
        for (int t = 0; t < 4 && accepts == a0; t++) cycle(4095, 0, e);
        wr_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle(xs[i], ys[i], e);
            if (i == 0) e = 24'hFF0000;
            if (i == 1 || i == 3 || i == 4) e = BG;
            q.push_back(e);
            if (q.size() == 5) begin
                w = q.pop_front();
                checks++;
                if (rgb !== w) begin
                    $display("FAIL directed sample %0d got %h want %h", i - 4, rgb, w);
                    errors++;
                end
            end
        end
    endtask

    task automatic test_arbitration();
        logic [23:0] q [$];
        logic [23:0] e, w;
        logic [10:0] addr;
        int          a0;
        addr = 11'(6 * 32 + 10);
        cycle(0, 100, e);
        q.push_back(e);
        wr_addr  = addr;
        wr_data  = {model_map[addr][13:8] ^ 6'h2A, 8'($urandom)};
        wr_valid = 1'b1;
        a0       = accepts;
        for (int x = 1; x < 448; x++) begin
            cycle(x, 100, e);
            q.push_back(e);
            if (q.size() == 5) begin
                w = q.pop_front();
                checks++;
                if (rgb !== w) begin
                    $display("FAIL arb_sweep x %0d got %h want %h", x - 4, rgb, w);
                    errors++;
                end
            end
            checks++;
            if (wr_ready !== 1'b0) begin
                $display("FAIL arb_ready x %0d got %b want 0", x, wr_ready);
                errors++;
            end
        end
        for (int t = 0; t < 6; t++) begin
            cycle(4095, 100, e);
            if (accepts != a0) wr_valid = 1'b0;
            q.push_back(e);
            w = q.pop_front();
            checks++;
            if (rgb !== w) begin
                $display("FAIL arb_margin %0d got %h want %h", t, rgb, w);
                errors++;
            end
        end
        wr_valid = 1'b0;
        checks++;
        if (accepts - a0 != 1) begin
            $display("FAIL arb_transfers got %0d want 1", accepts - a0);
            errors++;
        end
        for (int x = 160; x < 180; x++) begin
            cycle(x < 176 ? x : 4095, 100, e);
            q.push_back(e);
            w = q.pop_front();
            checks++;
            if (rgb !== w) begin
                $display("FAIL arb_readback x %0d got %h want %h", x, rgb, w);
                errors++;
            end
        end
    endtask

    task automatic test_random();
        logic [23:0] q [$];
        logic [23:0] e, w;
        int          a0, x, y;
        for (int i = 0; i < 1500; i++) begin
            if (!wr_valid && $urandom_range(0, 3) == 0) begin
                wr_valid = 1'b1;
                wr_addr  = ($urandom_range(0, 3) == 0) ? 11'($urandom)
                         : 11'($urandom_range(0, 35) * 32 + $urandom_range(0, 27));
                wr_data  = 14'($urandom);
            end
            x  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4095))
                                            : int'($urandom_range(0, 460));
            y  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2047))
                                            : int'($urandom_range(0, 600));
            if (i >= 1496) begin
                x = 4095;
                y = 0;
            end
            a0 = accepts;
            cycle(x, y, e);
            if (accepts != a0) wr_valid = 1'b0;
            q.push_back(e);
            if (q.size() == 5) begin
                w = q.pop_front();
                checks++;
                if (rgb !== w) begin
                    $display("FAIL random sample %0d got %h want %h", i - 4, rgb, w);
                    errors++;
                end
            end
        end
        for (int t = 0; t < 4 && wr_valid; t++) begin
            a0 = accepts;
            cycle(4095, 0, e);
            if (accepts != a0) wr_valid = 1'b0;
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic [23:0] q [$];
        logic [23:0] e, w;
        for (int x = 0; x < 100; x++) cycle(x * 4, 200, e);
        nRST = 1'b0;
        #1;
        checks++;
        if (rgb !== 24'h0) begin
            $display("FAIL midreset_rgb got %h want 000000", rgb);
            errors++;
        end
        checks++;
        if (wr_ready !== 1'b1) begin
            $display("FAIL midreset_wr_ready got %b want 1", wr_ready);
            errors++;
        end
        @(posedge PixelClk);
        #1;
        nRST = 1'b1;
        repeat (4) q.push_back(24'h0);
        for (int i = 0; i < 160; i++) begin
            cycle(i < 156 ? int'($urandom_range(0, 450)) : 4095,
                  i < 156 ? int'($urandom_range(0, 580)) : 0, e);
            q.push_back(e);
            w = q.pop_front();
            checks++;
            if (rgb !== w) begin
                $display("FAIL midreset_resume sample %0d got %h want %h", i - 4, rgb, w);
                errors++;
            end
        end
    endtask

`ifdef TILE_RENDER_PAL_WR_EN
    task automatic test_pal_write();
        logic [23:0] q [$];
        logic [23:0] e, w;
        int          a0;
        wr_addr  = 11'(2 * 32 + 3);
        wr_data  = {6'd1, 8'd5};
        wr_valid = 1'b1;
        a0       = accepts;
        for (int t = 0; t < 4 && accepts == a0; t++) cycle(4095, 0, e);
        wr_valid = 1'b0;
        // Sample 3's palette read shares the edge with the write.
        for (int k = 1; k <= 12; k++) begin
            pal_we   = (k == 6);
            pal_addr = 8'd7;
            pal_data = 24'h00FF00;
            cycle(48, 32, e);
            q.push_back((k <= 3) ? 24'hFF0000 : 24'h00FF00);
            if (q.size() == 5) begin
                w = q.pop_front();
                checks++;
                if (rgb !== w) begin
                    $display("FAIL pal_write sample %0d got %h want %h", k - 4, rgb, w);
                    errors++;
                end
            end
        end
        pal_we       = 1'b0;
        model_pal[7] = 24'h00FF00;
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) begin
            model_pal[i] = (i == 7) ? 24'hFF0000
                         : 24'((i << 16) | ((255 - i) << 8) | (i ^ 90));
        end
        #12;
        nRST = 1'b1;
        @(posedge PixelClk);
        #1;
        test_fill();
        test_reset();
        test_directed();
        test_arbitration();
        test_random();
        test_mid_reset();
`ifdef TILE_RENDER_PAL_WR_EN
        test_pal_write();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
